// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed seven-segment scan controller.
// Scans NUM_DIGITS digits with per-digit dwell, frame-coherent input
// snapshots, per-digit blink, PWM brightness and a frame-boundary pulse.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 6,
    parameter int SCAN_DIV     = 8192,
    parameter int BRIGHT_W     = 3,
    parameter int BLINK_FRAMES = 128
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_enable,
    input  logic [7*NUM_DIGITS-1:0] i_digit_seg,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    input  logic [NUM_DIGITS-1:0]   i_blink_en,
    input  logic [BRIGHT_W-1:0]     i_bright,
    output logic [6:0]              o_seg,
    output logic                    o_seg_dp,
    output logic [NUM_DIGITS-1:0]   o_seg_enb,
    output logic                    o_frame_tick
);

    localparam int DWELL_W = $clog2(SCAN_DIV);
    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int FRAME_W = $clog2(BLINK_FRAMES) + 1;
    localparam int PW      = DWELL_W + 1;
    localparam int SLICE   = SCAN_DIV >> BRIGHT_W;

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);
    localparam logic [PW-1:0]      SLICE_PW   = PW'(SLICE);

    // scan state
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               blink_phase_q, blink_phase_d;
    logic               init_q, init_d;
    logic               en_prev_q, en_prev_d;
    logic [BRIGHT_W-1:0] bright_q, bright_d;

    // shadow (snapshot) registers
    logic [7*NUM_DIGITS-1:0] seg_sh_q, seg_sh_d;
    logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
    logic [NUM_DIGITS-1:0]   blink_sh_q, blink_sh_d;

    // registered outputs
    logic [6:0]            seg_out_q, seg_out_d;
    logic                  dp_out_q, dp_out_d;
    logic [NUM_DIGITS-1:0] enb_out_q, enb_out_d;
    logic                  tick_q, tick_d;

    logic frame_wrap;
    logic en_rise;
    logic snap_load;

    // Counter chain: dwell -> digit index -> frame -> blink phase; cleared while disabled
    always_comb begin
        dwell_d       = dwell_q;
        idx_d         = idx_q;
        frame_d       = frame_q;
        blink_phase_d = blink_phase_q;
        frame_wrap    = i_enable && (dwell_q == DWELL_LAST) && (idx_q == IDX_LAST);
        if (!i_enable) begin
            dwell_d       = '0;
            idx_d         = '0;
            frame_d       = '0;
            blink_phase_d = 1'b0;
        end else if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
                if (frame_q == FRAME_LAST) begin
                    frame_d       = '0;
                    blink_phase_d = ~blink_phase_q;
                end else begin
                    frame_d = frame_q + FRAME_W'(1);
                end
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            dwell_d = dwell_q + DWELL_W'(1);
        end
    end

    // Snapshot control: load after reset release, at frame wrap and on enable rising
    always_comb begin
        init_d     = 1'b1;
        en_prev_d  = i_enable;
        en_rise    = i_enable && !en_prev_q;
        snap_load  = !init_q || frame_wrap || en_rise;
        seg_sh_d   = snap_load ? i_digit_seg : seg_sh_q;
        dp_sh_d    = snap_load ? i_dp        : dp_sh_q;
        blink_sh_d = snap_load ? i_blink_en  : blink_sh_q;
        bright_d   = (dwell_q == '0) ? i_bright : bright_q;
    end

    // Output selection: pick active digit, apply PWM/blink/enable gating.
    // On a restart cycle (reset release or enable rising) the inputs are
    // used directly so the very first lit cycle already shows fresh data.
    always_comb begin
        logic                    bypass;
        logic [7*NUM_DIGITS-1:0] disp_seg;
        logic [NUM_DIGITS-1:0]   disp_dp;
        logic [NUM_DIGITS-1:0]   disp_blink;
        logic [6:0]              cur_seg;
        logic                    cur_dp;
        logic                    cur_blink;
        logic [PW-1:0]           thr;
        logic                    pwm_on;
        logic                    lit;

        bypass     = !init_q || en_rise;
        disp_seg   = bypass ? i_digit_seg : seg_sh_q;
        disp_dp    = bypass ? i_dp        : dp_sh_q;
        disp_blink = bypass ? i_blink_en  : blink_sh_q;

        cur_seg   = '0;
        cur_dp    = 1'b0;
        cur_blink = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_seg   = disp_seg[7*k +: 7];
                cur_dp    = disp_dp[k];
                cur_blink = disp_blink[k];
            end
        end

        // Compare one bit wider than dwell so all-ones brightness reaches SCAN_DIV.
        thr    = (PW'(bright_q) + PW'(1)) * SLICE_PW;
        pwm_on = ({1'b0, dwell_q} < thr);
        lit    = i_enable && pwm_on && !(cur_blink && blink_phase_q);

        enb_out_d = '1;
        seg_out_d = '0;
        dp_out_d  = 1'b0;
        if (lit) begin
            seg_out_d = cur_seg;
            dp_out_d  = cur_dp;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (idx_q == IDX_W'(k)) begin
                    enb_out_d[k] = 1'b0;
                end
            end
        end
        tick_d = frame_wrap;
    end

    // State, shadow and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_q       <= '0;
            idx_q         <= '0;
            frame_q       <= '0;
            blink_phase_q <= 1'b0;
            init_q        <= 1'b0;
            en_prev_q     <= 1'b0;
            bright_q      <= '0;
            seg_sh_q      <= '0;
            dp_sh_q       <= '0;
            blink_sh_q    <= '0;
            seg_out_q     <= '0;
            dp_out_q      <= 1'b0;
            enb_out_q     <= '1;
            tick_q        <= 1'b0;
        end else begin
            dwell_q       <= dwell_d;
            idx_q         <= idx_d;
            frame_q       <= frame_d;
            blink_phase_q <= blink_phase_d;
            init_q        <= init_d;
            en_prev_q     <= en_prev_d;
            bright_q      <= bright_d;
            seg_sh_q      <= seg_sh_d;
            dp_sh_q       <= dp_sh_d;
            blink_sh_q    <= blink_sh_d;
            seg_out_q     <= seg_out_d;
            dp_out_q      <= dp_out_d;
            enb_out_q     <= enb_out_d;
            tick_q        <= tick_d;
        end
    end

    assign o_seg        = seg_out_q;
    assign o_seg_dp     = dp_out_q;
    assign o_seg_enb    = enb_out_q;
    assign o_frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with 4 digits, dwell 8, 2-bit brightness,
// blink half-period of 2 frames (one frame = 32 clocks).
module tb_seg_scan_ctrl;

    localparam int ND = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_enable;
    logic [7*ND-1:0] i_digit_seg;
    logic [ND-1:0] i_dp;
    logic [ND-1:0] i_blink_en;
    logic [1:0]    i_bright;
    logic [6:0]    o_seg;
    logic          o_seg_dp;
    logic [ND-1:0] o_seg_enb;
    logic          o_frame_tick;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] seg_tbl [4];
    logic [3:0] dp_v;

    seg_scan_ctrl #(
        .NUM_DIGITS  (4),
        .SCAN_DIV    (8),
        .BRIGHT_W    (2),
        .BLINK_FRAMES(2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_enable    (i_enable),
        .i_digit_seg (i_digit_seg),
        .i_dp        (i_dp),
        .i_blink_en  (i_blink_en),
        .i_bright    (i_bright),
        .o_seg       (o_seg),
        .o_seg_dp    (o_seg_dp),
        .o_seg_enb   (o_seg_enb),
        .o_frame_tick(o_frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_digits();
        i_digit_seg = {seg_tbl[3], seg_tbl[2], seg_tbl[1], seg_tbl[0]};
        i_dp        = dp_v;
    endtask

    task automatic chk_dark(input string tag);
        chk({tag, "_enb"},  32'(o_seg_enb),    32'hF);
        chk({tag, "_seg"},  32'(o_seg),        32'h0);
        chk({tag, "_dp"},   32'(o_seg_dp),     32'h0);
        chk({tag, "_tick"}, 32'(o_frame_tick), 32'h0);
    endtask

    // Hold reset for two clocks, check reset outputs, release just after an edge.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        step();
        step();
        chk_dark(tag);
        rst_n = 1'b1;
    endtask

    // Check ncyc output cycles counted from the first edge of a fresh scan.
    // Digit d = (k mod 32)/8 is lit for the first on_cyc cycles of its dwell,
    // except blinking digits, which are dark in frames 2,3 of every 4.
    task automatic run_scan(input int ncyc, input int on_cyc, input logic [3:0] blink,
                            input string tag);
        for (int k = 0; k < ncyc; k++) begin
            int         d;
            int         f;
            logic       lit;
            logic [3:0] e_enb;
            logic [6:0] e_seg;
            logic       e_dp;
            step();
            d     = (k % 32) / 8;
            f     = k / 32;
            lit   = ((k % 8) < on_cyc) && !(blink[d] && ((f / 2) % 2 == 1));
            e_enb = 4'hF;
            e_seg = 7'h00;
            e_dp  = 1'b0;
            if (lit) begin
                e_enb    = 4'hF;
                e_enb[d] = 1'b0;
                e_seg    = seg_tbl[d];
                e_dp     = dp_v[d];
            end
            chk({tag, "_enb"},  32'(o_seg_enb),    32'(e_enb));
            chk({tag, "_seg"},  32'(o_seg),        32'(e_seg));
            chk({tag, "_dp"},   32'(o_seg_dp),     32'(e_dp));
            chk({tag, "_tick"}, 32'(o_frame_tick), 32'((k % 32) == 31));
        end
    endtask

    initial begin
        logic [6:0] n1;
        logic [6:0] n3;

        rst_n      = 1'b0;
        i_enable   = 1'b1;
        i_bright   = 2'd3;
        i_blink_en = 4'b0000;
        seg_tbl[0] = 7'h33;
        seg_tbl[1] = 7'h79;
        seg_tbl[2] = 7'h6D;
        seg_tbl[3] = 7'h30;
        dp_v       = 4'b1001;
        apply_digits();

        // 1: full brightness scan, 1110/1101/1011/0111, tick every 32 cycles
        do_reset("t1_rst");
        run_scan(64, 8, 4'b0000, "t1");

        // 2: brightness 0 -> 2 of 8 lit, 1 -> 4 of 8, 2 -> 6 of 8
        i_bright = 2'd0;
        do_reset("t2a_rst");
        run_scan(32, 2, 4'b0000, "t2a");
        i_bright = 2'd1;
        do_reset("t2b_rst");
        run_scan(32, 4, 4'b0000, "t2b");
        i_bright = 2'd2;
        do_reset("t2c_rst");
        run_scan(32, 6, 4'b0000, "t2c");

        // 3: digit1 blinks with a 4-frame period, others steady
        i_bright   = 2'd3;
        i_blink_en = 4'b0010;
        do_reset("t3_rst");
        run_scan(160, 8, 4'b0010, "t3");

        // 4: change digits 1 and 3 while digit2 is active; new data only next frame
        i_blink_en = 4'b0000;
        n1 = 7'h7F;
        n3 = 7'h06;
        do_reset("t4_rst");
        for (int k = 0; k < 64; k++) begin
            int         d;
            logic [6:0] e_seg;
            step();
            d     = (k % 32) / 8;
            e_seg = seg_tbl[d];
            if (k >= 32 && d == 1) e_seg = n1;
            if (k >= 32 && d == 3) e_seg = n3;
            chk("t4_seg", 32'(o_seg), 32'(e_seg));
            if (k == 18) begin
                i_digit_seg[13:7]  = n1;
                i_digit_seg[27:21] = n3;
            end
        end
        seg_tbl[1] = n1;
        seg_tbl[3] = n3;

        // 5: drop enable at dwell 3 of digit2, then re-enable with fresh data
        do_reset("t5_rst");
        run_scan(19, 8, 4'b0000, "t5a");
        i_enable = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            chk_dark("t5_off");
        end
        seg_tbl[0] = 7'h5B;
        seg_tbl[1] = 7'h66;
        seg_tbl[2] = 7'h3F;
        seg_tbl[3] = 7'h07;
        dp_v       = 4'b0110;
        apply_digits();
        i_enable = 1'b1;
        run_scan(64, 8, 4'b0000, "t5b");

        // 6: asynchronous reset mid-dwell while blink phase is 1
        i_blink_en = 4'b0010;
        do_reset("t6_rst");
        run_scan(70, 8, 4'b0010, "t6a");
        #2;
        rst_n = 1'b0;
        #1;
        chk_dark("t6_async");
        rst_n = 1'b1;
        run_scan(96, 8, 4'b0010, "t6b");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
